// File: rtl/memory_arbiter.sv
// memory_arbiter
//   Controller end of the icache/dcache interface. Accepts one request at a
//   time from either cache and forwards it to the single RAM port. The wait
//   pulse (with its load data) is returned to the requester that was served.
//   Data requests win over instruction requests.
//
// Ports
//   CLK, RST             clock; asynchronous active-high reset
//   iREN, iaddr          icache read request (held until iwait low) and address
//   iwait, iload         icache handshake: iwait low for the completing cycle
//   dREN, dWEN           dcache read / write request (held until dwait low)
//   daddr, dstore        dcache address and write data
//   dwait, dload         dcache handshake: dwait low for the completing cycle
//   ramREN, ramWEN       RAM strobes
//   ramaddr, ramstore    RAM address and write data
//   ramload, ramstate    RAM read data and status (FREE/BUSY/ACCESS/ERROR)
//   ram_err              sticky flag, set by any ERROR completion
//
// Configuration
//   MEMARB_STARVE_GUARD_EN  when defined, a 3-bit saturating counter tracks
//   data grants taken while an instruction read was pending; once it reaches
//   STARVE_LIMIT the next arbitration with iREN high goes to the icache.
//   Undefined: strict data priority, no counter and no STARVE_LIMIT parameter.

module memory_arbiter
`ifdef MEMARB_STARVE_GUARD_EN
#(
  parameter int STARVE_LIMIT = 4
)
`endif
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        iwait,
  output logic        dwait,
  output logic [31:0] iload,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        ram_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } state_t;

  localparam logic [1:0]  RAM_ACCESS = 2'd2;
  localparam logic [1:0]  RAM_ERROR  = 2'd3;
  localparam logic [31:0] ERR_WORD   = 32'hBAD1BAD1;

  state_t state_q, state_d;
  logic   ram_err_q, ram_err_d;
  logic   d_req;
  logic   ram_done;
  logic   granted_live;

`ifdef MEMARB_STARVE_GUARD_EN
  localparam logic [2:0] STARVE_LIM = 3'(STARVE_LIMIT);
  logic [2:0] starve_cnt_q, starve_cnt_d;
`endif

  // An ERROR completion replaces whatever the RAM returned.
  function automatic logic [31:0] load_sel(input logic [1:0]  st,
                                           input logic [31:0] data);
    return (st == RAM_ERROR) ? ERR_WORD : data;
  endfunction

  assign d_req    = dREN | dWEN;
  assign ram_done = (ramstate == RAM_ACCESS) || (ramstate == RAM_ERROR);

  // A grant only drives the RAM while its requester still holds the request.
  assign granted_live = ((state_q == IGRANT) && iREN) ||
                        ((state_q == DGRANT) && d_req);

  // Next-state and sticky error
  always_comb begin
    state_d   = state_q;
    ram_err_d = ram_err_q;
`ifdef MEMARB_STARVE_GUARD_EN
    starve_cnt_d = starve_cnt_q;
`endif

    case (state_q)
      IDLE: begin
`ifdef MEMARB_STARVE_GUARD_EN
        if (iREN && (starve_cnt_q >= STARVE_LIM)) state_d = IGRANT;
        else
`endif
        if (d_req)     state_d = DGRANT;
        else if (iREN) state_d = IGRANT;
      end
      // A dropped request abandons the grant without a wait pulse.
      IGRANT:  if (!iREN || ram_done)  state_d = IDLE;
      DGRANT:  if (!d_req || ram_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (granted_live && (ramstate == RAM_ERROR)) ram_err_d = 1'b1;

`ifdef MEMARB_STARVE_GUARD_EN
    if (state_q == IDLE) begin
      if (state_d == IGRANT)
        starve_cnt_d = 3'd0;
      else if ((state_d == DGRANT) && iREN && (starve_cnt_q != 3'd7))
        starve_cnt_d = starve_cnt_q + 3'd1;
    end
`endif
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      ram_err_q <= 1'b0;
`ifdef MEMARB_STARVE_GUARD_EN
      starve_cnt_q <= 3'd0;
`endif
    end else begin
      state_q   <= state_d;
      ram_err_q <= ram_err_d;
`ifdef MEMARB_STARVE_GUARD_EN
      starve_cnt_q <= starve_cnt_d;
`endif
    end
  end

  // RAM port and cache handshakes are combinational on the registered state,
  // so the completing cycle drops wait in the same cycle RAM reports it, and
  // an asynchronous reset clears the strobes at once.
  always_comb begin
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = 32'd0;
    dload    = 32'd0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = 32'd0;
    ramstore = 32'd0;

    case (state_q)
      IGRANT: begin
        if (iREN) begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
          if (ram_done) begin
            iwait = 1'b0;
            iload = load_sel(ramstate, ramload);
          end
        end
      end
      DGRANT: begin
        if (d_req) begin
          ramaddr  = daddr;
          ramstore = dstore;
          // Write wins when both strobes are requested.
          ramWEN   = dWEN;
          ramREN   = dREN & ~dWEN;
          if (ram_done) begin
            dwait = 1'b0;
            dload = load_sel(ramstate, dWEN ? 32'd0 : ramload);
          end
        end
      end
      default: ;
    endcase
  end

  assign ram_err = ram_err_q;

endmodule

// File: tb/tb_memory_arbiter.sv
module tb_memory_arbiter;

  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;
  localparam int STARVE_LIMIT   = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore;
  logic        iwait, dwait;
  logic [31:0] iload, dload;
  logic        ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore, ramload;
  logic [1:0]  ramstate;
  logic        ram_err;

  int n_chk = 0;
  int n_err = 0;

  // RAM contents as seen by the RAM, and as expected by the requesters.
  logic [31:0] ram_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  always #5 CLK = ~CLK;

  memory_arbiter dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .ram_err(ram_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5555AAAA;
  endfunction

  function automatic logic [31:0] ram_rd(input logic [31:0] a);
    return ram_mem.exists(a) ? ram_mem[a] : dflt(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  task automatic clear_inputs();
    iREN = 0; dREN = 0; dWEN = 0;
    iaddr = 0; daddr = 0; dstore = 0;
    ramstate = FREE; ramload = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int order_i_pos, d_cnt, exp_pos, scnt, dleft;
    bit i_seen;
    bit i_act, i_done, d_act, d_done, d_wr, ram_busy;
    int i_age, d_age, ram_lat, r;

    clear_inputs();
    RST = 1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_iwait", 32'(iwait), 1);
    chk("rst_dwait", 32'(dwait), 1);
    chk("rst_iload", iload, 0);
    chk("rst_dload", dload, 0);
    chk("rst_ramREN", 32'(ramREN), 0);
    chk("rst_ramWEN", 32'(ramWEN), 0);
    chk("rst_ramaddr", ramaddr, 0);
    chk("rst_ramstore", ramstore, 0);
    chk("rst_ram_err", 32'(ram_err), 0);
    @(posedge CLK); #1 RST = 0;

    // I read, two BUSY cycles then ACCESS
    @(posedge CLK); #1 iREN = 1; iaddr = 32'h40;
    @(negedge CLK); chk("t1_idle_ren", 32'(ramREN), 0); chk("t1_idle_iwait", 32'(iwait), 1);
    @(posedge CLK); #1 ramstate = BUSY;
    @(negedge CLK); chk("t1_ren", 32'(ramREN), 1); chk("t1_addr", ramaddr, 32'h40);
    chk("t1_busy1_iwait", 32'(iwait), 1);
    @(posedge CLK); #1;
    @(negedge CLK); chk("t1_busy2_iwait", 32'(iwait), 1);
    @(posedge CLK); #1 ramstate = ACCESS; ramload = 32'h12345678;
    @(negedge CLK); chk("t1_iwait_low", 32'(iwait), 0); chk("t1_iload", iload, 32'h12345678);
    chk("t1_dwait", 32'(dwait), 1);
    @(posedge CLK); #1 iREN = 0; ramstate = FREE;
    @(negedge CLK); chk("t1_after_iwait", 32'(iwait), 1); chk("t1_after_iload", iload, 0);
    chk("t1_after_ren", 32'(ramREN), 0);

    // Simultaneous I read and D write: D first
    @(posedge CLK); #1 iREN = 1; iaddr = 32'h44; dWEN = 1; daddr = 32'h80; dstore = 32'hCAFEF00D;
    @(negedge CLK); chk("t2_idle_wen", 32'(ramWEN), 0);
    @(posedge CLK); #1 ramstate = ACCESS;
    @(negedge CLK);
    chk("t2_wen", 32'(ramWEN), 1); chk("t2_ren", 32'(ramREN), 0);
    chk("t2_addr", ramaddr, 32'h80); chk("t2_store", ramstore, 32'hCAFEF00D);
    chk("t2_dwait", 32'(dwait), 0); chk("t2_iwait_hi", 32'(iwait), 1);
    @(posedge CLK); #1 dWEN = 0; ramstate = FREE;
    @(negedge CLK); chk("t2_gap_iwait", 32'(iwait), 1); chk("t2_gap_ren", 32'(ramREN), 0);
    @(posedge CLK); #1 ramstate = ACCESS; ramload = 32'h11110044;
    @(negedge CLK);
    chk("t2_i_ren", 32'(ramREN), 1); chk("t2_i_addr", ramaddr, 32'h44);
    chk("t2_iwait", 32'(iwait), 0); chk("t2_iload", iload, 32'h11110044);
    @(posedge CLK); #1 iREN = 0; ramstate = FREE;

    // dREN and dWEN together: write wins
    @(posedge CLK); #1 dREN = 1; dWEN = 1; daddr = 32'h10; dstore = 32'h5A5A0001;
    @(negedge CLK);
    @(posedge CLK); #1 ramstate = BUSY;
    @(negedge CLK); chk("t3_wen", 32'(ramWEN), 1); chk("t3_ren", 32'(ramREN), 0);
    chk("t3_busy_dwait", 32'(dwait), 1);
    @(posedge CLK); #1 ramstate = ACCESS;
    @(negedge CLK); chk("t3_dwait", 32'(dwait), 0);
    @(posedge CLK); #1 dREN = 0; dWEN = 0; ramstate = FREE;
    @(negedge CLK); chk("t3_after_dwait", 32'(dwait), 1); chk("t3_after_wen", 32'(ramWEN), 0);

    // ERROR on a D read
    @(posedge CLK); #1 dREN = 1; daddr = 32'h20;
    @(negedge CLK);
    @(posedge CLK); #1 ramstate = ERROR; ramload = 32'h77777777;
    @(negedge CLK); chk("t4_dwait", 32'(dwait), 0); chk("t4_dload", dload, 32'hBAD1BAD1);
    chk("t4_err_before_edge", 32'(ram_err), 0);
    @(posedge CLK); #1 dREN = 0; ramstate = FREE;
    @(negedge CLK); chk("t4_err_set", 32'(ram_err), 1);
    @(posedge CLK); #1 iREN = 1; iaddr = 32'h0;
    @(negedge CLK);
    @(posedge CLK); #1 ramstate = ACCESS; ramload = 32'h1;
    @(negedge CLK); chk("t4_next_iwait", 32'(iwait), 0);
    @(posedge CLK); #1 iREN = 0; ramstate = FREE;
    @(negedge CLK); chk("t4_err_sticky", 32'(ram_err), 1);

    // Request dropped while granted
    @(posedge CLK); #1 dREN = 1; daddr = 32'h30;
    @(negedge CLK);
    @(posedge CLK); #1 ramstate = BUSY;
    @(negedge CLK); chk("t5_ren", 32'(ramREN), 1);
    dREN = 0;
    #1 chk("t5_drop_ren", 32'(ramREN), 0); chk("t5_drop_dwait", 32'(dwait), 1);
    @(posedge CLK); #1 ramstate = FREE;
    @(negedge CLK); chk("t5_after_dwait", 32'(dwait), 1);

    // Reset in the middle of a BUSY D grant
    @(posedge CLK); #1 dREN = 1; daddr = 32'h34;
    @(negedge CLK);
    @(posedge CLK); #1 ramstate = BUSY;
    @(negedge CLK); chk("t6_ren", 32'(ramREN), 1);
    #2 RST = 1;
    #1 chk("t6_rst_ren", 32'(ramREN), 0); chk("t6_rst_wen", 32'(ramWEN), 0);
    chk("t6_rst_addr", ramaddr, 0); chk("t6_rst_err", 32'(ram_err), 0);
    @(posedge CLK); #1 dREN = 0; ramstate = FREE;
    @(posedge CLK); #1 RST = 0;
    @(negedge CLK); chk("t6_iwait", 32'(iwait), 1); chk("t6_dwait", 32'(dwait), 1);
    chk("t6_ren_idle", 32'(ramREN), 0);
    @(posedge CLK); #1 iREN = 1; iaddr = 32'h48;
    @(negedge CLK); chk("t6_idle_arb", 32'(ramREN), 0);
    @(posedge CLK); #1 ramstate = ACCESS; ramload = 32'h48484848;
    @(negedge CLK); chk("t6_igrant_iwait", 32'(iwait), 0); chk("t6_iload", iload, 32'h48484848);
    @(posedge CLK); #1 iREN = 0; ramstate = FREE;

    // Starvation: dREN held for 5 transactions with iREN pending
    @(posedge CLK); #1 dREN = 1; daddr = 32'h60; iREN = 1; iaddr = 32'h64;
    d_cnt = 0; i_seen = 0; order_i_pos = -1;
    for (int c = 0; c < 60; c++) begin
      @(posedge CLK); #1;
      if (d_cnt >= 5) dREN = 0;
      if (i_seen) iREN = 0;
      #1 ramstate = (ramREN | ramWEN) ? ACCESS : FREE; ramload = 32'h99;
      @(negedge CLK);
      if (!dwait) d_cnt++;
      if (!iwait) begin i_seen = 1; order_i_pos = d_cnt; end
      if (i_seen && d_cnt >= 5 && !dREN && !iREN) break;
    end
    // Reference: count data wins before the instruction read is let through.
    scnt = 0; dleft = 5; exp_pos = 0;
`ifdef MEMARB_STARVE_GUARD_EN
    while (dleft > 0 && scnt < STARVE_LIMIT) begin dleft--; scnt++; exp_pos++; end
`else
    while (dleft > 0) begin dleft--; scnt++; exp_pos++; end
`endif
    chk("starve_i_seen", 32'(i_seen), 1);
    chk("starve_d_count", 32'(d_cnt), 5);
    chk("starve_i_pos", 32'(order_i_pos), 32'(exp_pos));
    @(posedge CLK); #1 clear_inputs();

    // Randomized traffic against a RAM model and a reference memory
    i_act = 0; i_done = 0; d_act = 0; d_done = 0; d_wr = 0; ram_busy = 0;
    i_age = 0; d_age = 0; ram_lat = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge CLK); #1;
      if (i_done) begin
        iREN = 0; i_act = 0; i_done = 0; i_age = 0;
      end else if (!i_act && $urandom_range(0, 1) == 0) begin
        iREN = 1; iaddr = 32'($urandom_range(0, 7)); i_act = 1; i_age = 0;
      end
      if (d_done) begin
        dREN = 0; dWEN = 0; d_act = 0; d_done = 0; d_age = 0;
      end else if (!d_act && $urandom_range(0, 2) == 0) begin
        r = int'($urandom_range(0, 2));
        dREN = (r != 1); dWEN = (r != 0); d_wr = dWEN;
        daddr = 32'($urandom_range(0, 7)); dstore = $urandom; d_act = 1; d_age = 0;
      end
      #1;
      if (ramREN | ramWEN) begin
        if (!ram_busy) begin ram_busy = 1; ram_lat = int'($urandom_range(0, 2)); end
        if (ram_lat == 0) begin
          ramstate = ACCESS;
          ramload = ramREN ? ram_rd(ramaddr) : 32'hDEADDEAD;
        end else begin
          ramstate = BUSY; ram_lat--; ramload = 32'hDEADDEAD;
        end
      end else begin
        ramstate = FREE; ram_busy = 0;
      end
      @(negedge CLK);
      chk("rnd_one_in_flight", 32'(!iwait && !dwait), 0);
      if (!dwait) begin
        if (d_wr) begin
          chk("rnd_wr_wen", 32'(ramWEN), 1);
          chk("rnd_wr_ren", 32'(ramREN), 0);
          chk("rnd_wr_addr", ramaddr, daddr);
          chk("rnd_wr_data", ramstore, dstore);
          ref_mem[daddr] = dstore;
        end else begin
          chk("rnd_dload", dload, ref_rd(daddr));
        end
        d_done = 1;
      end else begin
        chk("rnd_dload_idle", dload, 0);
      end
      if (!iwait) begin
        chk("rnd_iload", iload, ref_rd(iaddr));
        i_done = 1;
      end else begin
        chk("rnd_iload_idle", iload, 0);
      end
      if (ramstate == ACCESS) begin
        if (ramWEN) ram_mem[ramaddr] = ramstore;
        ram_busy = 0;
      end
      if (i_act && !i_done) i_age++;
      if (d_act && !d_done) d_age++;
      if (i_age > 200) begin chk("rnd_i_timeout", 32'(i_age), 0); i_done = 1; end
      if (d_age > 200) begin chk("rnd_d_timeout", 32'(d_age), 0); d_done = 1; end
    end
    chk("rnd_ram_err", 32'(ram_err), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
